alu_share_arbiter: RTL and testbench

//  Shares the single combinational 16-bit ALU between two requesters (0: datapath/accumulator

---
 rtl/alu_share_arbiter_pkg.sv | 40 ++++
 rtl/alu_share_arbiter_rr.sv | 20 ++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode map, FSM states and
// the compare-op classifier used when capturing ALU results.
package alu_share_arbiter_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned N_REQ    = 2;

  // ALU opcode map; 4'b1000-4'b1011 form the compare/branch group.
  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SHL   = 4'b0101,
    OP_SHR   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_BEQ   = 4'b1000,
    OP_BNE   = 4'b1001,
    OP_BLT   = 4'b1010,
    OP_BGE   = 4'b1011,
    OP_NOT   = 4'b1100,
    OP_INC   = 4'b1101,
    OP_DEC   = 4'b1110,
    OP_ADD8  = 4'b1111
  } alu_op_e;

  // Sharing FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // True for opcodes whose meaningful result is the branch flag.
  function automatic logic is_cmp(input logic [ALU_OP_W-1:0] op);
    return (op >= ALU_OP_W'(OP_BEQ)) && (op <= ALU_OP_W'(OP_BGE));
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin grant: with both requesters active, the one not granted
// last time wins; a lone requester always wins. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from current requests and the previous winner.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the datapath (requester 0) and the
// PC/branch-target path (requester 1). One op in flight; operands are held in
// registers for SETTLE_CYCLES, the result is captured and returned on a
// per-requester response handshake.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [N_REQ-1:0]    ReqValid,
  input  logic [ALU_OP_W-1:0] ReqOp0,
  input  logic [ALU_OP_W-1:0] ReqOp1,
  input  logic [DATA_W-1:0]   ReqA0,
  input  logic [DATA_W-1:0]   ReqA1,
  input  logic [DATA_W-1:0]   ReqB0,
  input  logic [DATA_W-1:0]   ReqB1,
  output logic [N_REQ-1:0]    ReqReady,
  output logic [N_REQ-1:0]    RespValid,
  input  logic [N_REQ-1:0]    RespReady,
  output logic [DATA_W-1:0]   RespData,
  output logic                RespBranch,
  output logic [ALU_OP_W-1:0] AluOp,
  output logic [DATA_W-1:0]   AluA,
  output logic [DATA_W-1:0]   AluB,
  input  logic [DATA_W-1:0]   AluOut,
  input  logic                AluBranch
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_e          r_state;
  arb_state_e          w_next;
  logic                r_last;
  logic                r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_branch;
  logic [N_REQ-1:0]    w_gnt;
  logic                w_accept;
  logic                w_sel;
  logic                w_settle_done;

  rr_arbiter2 u_rr (
    .req  (ReqValid),
    .last (r_last),
    .gnt  (w_gnt)
  );

  // Transfer qualification and settle-window completion.
  always_comb begin
    w_accept      = (r_state == ST_IDLE) && (|(ReqValid & w_gnt));
    w_sel         = w_gnt[1];
    w_settle_done = (r_state == ST_EXEC) && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)            w_next = ST_EXEC;
      ST_EXEC: if (w_settle_done)       w_next = ST_RESP;
      ST_RESP: if (RespReady[r_owner])  w_next = ST_IDLE;
      default:                          w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only while idle, respond only to the owner.
  always_comb begin
    ReqReady  = '0;
    RespValid = '0;
    case (r_state)
      ST_IDLE: ReqReady  = w_gnt;
      ST_RESP: RespValid = r_owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Operand registers, owner and last-grant update on transfer.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
    end else if (w_accept) begin
      r_alu_op <= w_sel ? ReqOp1 : ReqOp0;
      r_alu_a  <= w_sel ? ReqA1  : ReqA0;
      r_alu_b  <= w_sel ? ReqB1  : ReqB0;
      r_owner  <= w_sel;
      r_last   <= w_sel;
    end
  end

  // Settle counter: runs only in EXEC, cleared on the capture cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_EXEC) begin
      r_cnt <= w_settle_done ? '0 : r_cnt + 1'b1;
    end
  end

  // Result capture: keep only the ALU field that the opcode defines.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_resp_data   <= '0;
      r_resp_branch <= 1'b0;
    end else if (w_settle_done) begin
      if (is_cmp(r_alu_op)) begin
        r_resp_data   <= '0;
        r_resp_branch <= AluBranch;
      end else begin
        r_resp_data   <= AluOut;
        r_resp_branch <= 1'b0;
      end
    end
  end

  assign AluOp      = r_alu_op;
  assign AluA       = r_alu_a;
  assign AluB       = r_alu_b;
  assign RespData   = r_resp_data;
  assign RespBranch = r_resp_branch;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a settle-1 instance for most
// scenarios plus a settle-3 instance for latency/holding behaviour.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid    = 2'b00;
  logic [1:0]  s3_req_valid = 2'b00;
  logic [1:0]  resp_ready   = 2'b11;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [15:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;

  logic [1:0]  req_ready, resp_valid, s3_req_ready, s3_resp_valid;
  logic [15:0] resp_data, s3_resp_data;
  logic        resp_branch, s3_resp_branch;
  logic [3:0]  alu_op, s3_alu_op;
  logic [15:0] alu_a, alu_b, alu_out, s3_alu_a, s3_alu_b, s3_alu_out;
  logic        alu_branch, s3_alu_branch;

  int   checks   = 0;
  int   failures = 0;
  logic m_last   = 1'b1;

  always #5 clk = ~clk;

  // Ideal ALU behaviour: {branch, result}.
  function automatic logic [16:0] alu_math(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[3:0];
      4'd6:  r = a >> b[3:0];
      4'd7:  r = b;
      4'd8:  c = (a == b);
      4'd9:  c = (a != b);
      4'd10: c = ($signed(a) <  $signed(b));
      4'd11: c = ($signed(a) >= $signed(b));
      4'd12: r = ~a;
      4'd13: r = a + 16'd1;
      4'd14: r = a - 16'd1;
      default: r = {8'h00, a[7:0] + b[7:0]};
    endcase
    return {c, r};
  endfunction

  // ALU stand-in: the field the opcode does not define carries junk.
  function automatic logic [16:0] alu_stub(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] m;
    m = alu_math(op, a, b);
    if (op >= 4'd8 && op <= 4'd11) return {m[16], (a | b | 16'h8000)};
    return {1'b1, m[15:0]};
  endfunction

  // Expected response: compares return only the flag, others only the data.
  function automatic logic [16:0] ref_resp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] m;
    m = alu_math(op, a, b);
    if (op >= 4'd8 && op <= 4'd11) return {m[16], 16'h0000};
    return {1'b0, m[15:0]};
  endfunction

  assign {alu_branch, alu_out}       = alu_stub(alu_op, alu_a, alu_b);
  assign {s3_alu_branch, s3_alu_out} = alu_stub(s3_alu_op, s3_alu_a, s3_alu_b);

  alu_share_arbiter #(.DATA_W(16), .SETTLE_CYCLES(1)) dut (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid),
    .ReqOp0(op0), .ReqOp1(op1), .ReqA0(a0), .ReqA1(a1), .ReqB0(b0), .ReqB1(b1),
    .ReqReady(req_ready), .RespValid(resp_valid), .RespReady(resp_ready),
    .RespData(resp_data), .RespBranch(resp_branch),
    .AluOp(alu_op), .AluA(alu_a), .AluB(alu_b), .AluOut(alu_out), .AluBranch(alu_branch)
  );

  alu_share_arbiter #(.DATA_W(16), .SETTLE_CYCLES(3)) dut3 (
    .CLK(clk), .Reset(rst), .ReqValid(s3_req_valid),
    .ReqOp0(op0), .ReqOp1(op1), .ReqA0(a0), .ReqA1(a1), .ReqB0(b0), .ReqB1(b1),
    .ReqReady(s3_req_ready), .RespValid(s3_resp_valid), .RespReady(resp_ready),
    .RespData(s3_resp_data), .RespBranch(s3_resp_branch),
    .AluOp(s3_alu_op), .AluA(s3_alu_a), .AluB(s3_alu_b), .AluOut(s3_alu_out), .AluBranch(s3_alu_branch)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one op on requester r until it transfers (bounded), then drop it
  // and scramble the fields so any late resampling shows up.
  task automatic issue(input int r, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output bit ok);
    if (r == 0) begin op0 = op; a0 = a; b0 = b; end
    else        begin op1 = op; a1 = a; b1 = b; end
    req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      if (req_ready[r]) ok = 1'b1;
      step();
    end
    req_valid[r] = 1'b0;
    if (r == 0) begin op0 = 4'($urandom); a0 = 16'($urandom); b0 = 16'($urandom); end
    else        begin op1 = 4'($urandom); a1 = 16'($urandom); b1 = 16'($urandom); end
    if (ok) m_last = r[0];
  endtask

  // Wait (bounded) for any response; lat counts cycles from the accept cycle.
  task automatic collect(output logic [1:0] v, output logic [15:0] d, output logic br, output int lat, output bit ok);
    ok = 1'b0; lat = 0; v = '0; d = '0; br = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      if (resp_valid !== 2'b00) begin
        v = resp_valid; d = resp_data; br = resp_branch; lat = n + 1; ok = 1'b1;
      end
      step();
    end
  endtask

  task automatic test_reset;
    logic [1:0] v; logic [15:0] d; logic br; int lat; bit ok; int bad;
    rst = 1'b1;
    step(); step(); #1;
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_branch, alu_op, alu_a, alu_b} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h required=0", {req_ready, resp_valid, resp_data, resp_branch, alu_op, alu_a, alu_b});
    end
    checks++;
    if ({s3_req_ready, s3_resp_valid, s3_resp_data, s3_resp_branch, s3_alu_op, s3_alu_a, s3_alu_b} !== '0) begin
      failures++; $display("FAIL reset_outputs_s3 got=%h required=0", {s3_req_ready, s3_resp_valid, s3_resp_data, s3_resp_branch, s3_alu_op, s3_alu_a, s3_alu_b});
    end
    rst = 1'b0;
    step();
    issue(0, 4'h0, 16'h1111, 16'h2222, ok);
    collect(v, d, br, lat, ok);
    checks++;
    if (!ok || d !== 16'h3333) begin failures++; $display("FAIL pre_reset_op got=%h required=3333 ok=%0d", d, ok); end
    issue(0, 4'h3, 16'h00F0, 16'h0F00, ok);
    rst = 1'b1;
    step(); step(); #1;
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_branch, alu_op, alu_a, alu_b} !== '0) begin
      failures++; $display("FAIL reset_mid_exec got=%h required=0", {req_ready, resp_valid, resp_data, resp_branch, alu_op, alu_a, alu_b});
    end
    rst = 1'b0;
    m_last = 1'b1;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      step(); #1;
      if (resp_valid !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abandoned_op_resp got=%0d required=0 cycles with RespValid", bad); end
    op0 = 4'h0; a0 = 16'h0005; b0 = 16'h0006; op1 = 4'h0; a1 = 16'h0100; b1 = 16'h0200;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_last_grant got=%b required=01", req_ready); end
    step();
    req_valid = 2'b00;
    m_last = 1'b0;
    collect(v, d, br, lat, ok);
    checks++;
    if (!ok || v !== 2'b01 || d !== 16'h000B) begin failures++; $display("FAIL post_reset_op got=%b/%h required=01/000b", v, d); end
  endtask

  task automatic test_single;
    logic [1:0] v; logic [15:0] d; logic br; int lat; bit ok;
    issue(0, 4'h0, 16'h0003, 16'h0004, ok);
    checks++;
    if (!ok || alu_op !== 4'h0 || alu_a !== 16'h0003 || alu_b !== 16'h0004) begin
      failures++; $display("FAIL single_alu_regs got=%h/%h/%h required=0/0003/0004 ok=%0d", alu_op, alu_a, alu_b, ok);
    end
    collect(v, d, br, lat, ok);
    checks++;
    if (!ok || v !== 2'b01 || d !== 16'h0007 || br !== 1'b0) begin
      failures++; $display("FAIL single_add got=%b/%h/%b required=01/0007/0", v, d, br);
    end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL single_latency got=%0d required=2", lat); end
    #1;
    checks++;
    if (resp_valid !== 2'b00 || resp_data !== 16'h0007 || alu_a !== 16'h0003) begin
      failures++; $display("FAIL single_hold got=%b/%h/%h required=00/0007/0003", resp_valid, resp_data, alu_a);
    end
  endtask

  task automatic test_compare;
    logic [1:0] v; logic [15:0] d; logic br; int lat; bit ok;
    issue(1, 4'b1000, 16'h1234, 16'h1234, ok);
    collect(v, d, br, lat, ok);
    checks++;
    if (!ok || v !== 2'b10 || br !== 1'b1 || d !== 16'h0000) begin
      failures++; $display("FAIL cmp_equal got=%b/%h/%b required=10/0000/1", v, d, br);
    end
    issue(1, 4'b1000, 16'h1234, 16'h1235, ok);
    collect(v, d, br, lat, ok);
    checks++;
    if (!ok || v !== 2'b10 || br !== 1'b0 || d !== 16'h0000) begin
      failures++; $display("FAIL cmp_unequal got=%b/%h/%b required=10/0000/0", v, d, br);
    end
  endtask

  task automatic test_contention;
    logic [16:0] exp_q[$];
    int          own_q[$];
    logic [16:0] e;
    logic [1:0]  ev;
    int          g, o, n_acc, n_resp;
    n_acc = 0; n_resp = 0;
    op0 = 4'h1; a0 = 16'h0010; b0 = 16'h0001;
    op1 = 4'h3; a1 = 16'h00F0; b1 = 16'h000F;
    req_valid = 2'b11;
    for (int n = 0; n < 40 && n_resp < 4; n++) begin
      #1;
      if (resp_valid !== 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL contention_unexpected_resp got=%b required=none", resp_valid);
        end else begin
          e = exp_q.pop_front(); o = own_q.pop_front();
          ev = (o == 0) ? 2'b01 : 2'b10;
          if (resp_valid !== ev || resp_data !== e[15:0] || resp_branch !== e[16]) begin
            failures++; $display("FAIL contention_resp got=%b/%h/%b required=%b/%h/%b", resp_valid, resp_data, resp_branch, ev, e[15:0], e[16]);
          end
        end
        n_resp++;
      end
      if ((req_ready & req_valid) !== 2'b00) begin
        g = m_last ? 0 : 1;
        ev = (g == 0) ? 2'b01 : 2'b10;
        checks++;
        if (req_ready !== ev) begin failures++; $display("FAIL contention_grant got=%b required=%b (accept %0d)", req_ready, ev, n_acc); end
        m_last = g[0];
        own_q.push_back(g);
        exp_q.push_back((g == 0) ? ref_resp(op0, a0, b0) : ref_resp(op1, a1, b1));
        n_acc++;
        step();
        if (n_acc == 4) req_valid = 2'b00;
      end else begin
        step();
      end
    end
    req_valid = 2'b00;
    checks++;
    if (n_resp != 4) begin failures++; $display("FAIL contention_count got=%0d required=4 responses", n_resp); end
  endtask

  task automatic test_backpressure;
    logic [1:0] v; logic [15:0] d; logic br; int lat; bit ok, seen;
    logic [16:0] e, e1;
    int bad;
    resp_ready = 2'b10;
    e = ref_resp(4'h4, 16'hA5A5, 16'h0FF0);
    issue(0, 4'h4, 16'hA5A5, 16'h0FF0, ok);
    op1 = 4'h0; a1 = 16'h0101; b1 = 16'h0202;
    e1 = ref_resp(op1, a1, b1);
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      #1;
      if (resp_valid !== 2'b00) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_no_resp got=00 required=01"); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step(); #1; end
      if (resp_valid !== 2'b01 || resp_data !== e[15:0] || resp_branch !== e[16] || req_ready !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles required=0 (last %b/%h/%b)", bad, resp_valid, resp_data, req_ready); end
    resp_ready = 2'b11;
    step(); #1;
    checks++;
    if (req_ready !== 2'b10 || resp_valid !== 2'b00) begin failures++; $display("FAIL bp_release got=%b/%b required=10/00", req_ready, resp_valid); end
    step();
    req_valid[1] = 1'b0;
    m_last = 1'b1;
    collect(v, d, br, lat, ok);
    checks++;
    if (!ok || v !== 2'b10 || d !== e1[15:0] || br !== e1[16]) begin
      failures++; $display("FAIL bp_req1 got=%b/%h/%b required=10/%h/%b", v, d, br, e1[15:0], e1[16]);
    end
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int last_acc, n_acc, n_resp;
    bit acc;
    last_acc = -1; n_acc = 0; n_resp = 0;
    op0 = 4'h0; a0 = 16'($urandom); b0 = 16'($urandom);
    req_valid[0] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      #1;
      acc = 1'b0;
      if (resp_valid !== 2'b00) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1FFFF;
        if (resp_valid !== 2'b01 || resp_data !== e[15:0] || resp_branch !== e[16]) begin
          failures++; $display("FAIL b2b_resp got=%b/%h/%b required=01/%h/%b", resp_valid, resp_data, resp_branch, e[15:0], e[16]);
        end
        n_resp++;
      end
      if (req_ready[0]) begin
        if (last_acc >= 0) begin
          checks++;
          if (n - last_acc != 3) begin failures++; $display("FAIL b2b_gap got=%0d required=3", n - last_acc); end
        end
        last_acc = n;
        exp_q.push_back(ref_resp(op0, a0, b0));
        n_acc++;
        acc = 1'b1;
      end
      step();
      if (acc) begin op0 = 4'($urandom); a0 = 16'($urandom); b0 = 16'($urandom); end
    end
    req_valid[0] = 1'b0;
    m_last = 1'b0;
    step(); step();
    checks++;
    if (n_acc != 10 || n_resp != 10) begin failures++; $display("FAIL b2b_count got=%0d/%0d required=10/10", n_acc, n_resp); end
  endtask

  task automatic test_random;
    logic [1:0] v, ev; logic [15:0] d, a, b; logic br; int lat, r; bit ok, ok2;
    logic [3:0] op;
    logic [16:0] e;
    for (int i = 0; i < 24; i++) begin
      r  = int'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      e  = ref_resp(op, a, b);
      ev = (r == 0) ? 2'b01 : 2'b10;
      issue(r, op, a, b, ok);
      collect(v, d, br, lat, ok2);
      checks++;
      if (!ok || !ok2 || v !== ev || d !== e[15:0] || br !== e[16] || lat != 2) begin
        failures++;
        $display("FAIL random_op%0d got=%b/%h/%b lat=%0d required=%b/%h/%b lat=2 (op=%h a=%h b=%h)", i, v, d, br, lat, ev, e[15:0], e[16], op, a, b);
      end
    end
  endtask

  task automatic test_settle3;
    logic [3:0] sop; logic [15:0] sa, sb; logic [16:0] e;
    int lat, bad;
    bit acc;
    op0 = 4'h0; a0 = 16'h4321; b0 = 16'h1111;
    sop = op0; sa = a0; sb = b0;
    e = ref_resp(sop, sa, sb);
    s3_req_valid[0] = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      #1;
      if (s3_req_ready[0]) acc = 1'b1;
      step();
    end
    s3_req_valid[0] = 1'b0;
    op0 = 4'h2; a0 = 16'hFFFF; b0 = 16'h0000;
    checks++;
    if (!acc) begin failures++; $display("FAIL s3_accept got=none required=accept"); end
    lat = 0; bad = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      #1;
      if (s3_resp_valid !== 2'b00) lat = k;
      else if (s3_alu_op !== sop || s3_alu_a !== sa || s3_alu_b !== sb) bad++;
      step();
    end
    checks++;
    if (lat != 4) begin failures++; $display("FAIL s3_latency got=%0d required=4", lat); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL s3_alu_hold got=%0d unstable cycles required=0", bad); end
    checks++;
    if (s3_resp_data !== e[15:0] || s3_resp_branch !== e[16] || s3_alu_a !== sa) begin
      failures++; $display("FAIL s3_result got=%h/%b required=%h/%b", s3_resp_data, s3_resp_branch, e[15:0], e[16]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_compare();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_settle3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
